// File: rtl/neuron_pkg.sv
// Shared widths, frame record and FSM encoding for the neuron feeder and accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package neuron_pkg;

  localparam int X_W    = 10;
  localparam int W_W    = 10;
  localparam int P_W    = X_W + W_W;
  localparam int BIAS_W = 8;
  localparam int BEATS  = 4;
  localparam int BEAT_W = $clog2(BEATS);

  localparam logic [BEAT_W-1:0] FIRST_BEAT = '0;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // One captured operand set: all elements of x and w plus the frame bias.
  typedef struct packed {
    logic [BEATS*X_W-1:0] x;
    logic [BEATS*W_W-1:0] w;
    logic [BIAS_W-1:0]    bias;
  } frame_t;

  // Element k of a packed input vector, element 0 in the low bits.
  function automatic logic [X_W-1:0] elem_x(input logic [BEATS*X_W-1:0] v,
                                            input logic [BEAT_W-1:0] k);
    return v[k*X_W +: X_W];
  endfunction

  // Element k of a packed weight vector, element 0 in the low bits.
  function automatic logic [W_W-1:0] elem_w(input logic [BEATS*W_W-1:0] v,
                                            input logic [BEAT_W-1:0] k);
    return v[k*W_W +: W_W];
  endfunction

endpackage

// File: rtl/neuron_feeder_pipe_mult.sv
// Unsigned A_W x B_W multiplier with a single output register, full-width product.
// Latency: 1 cycle from operands to o_p when i_en is high.
// Backpressure: none; i_en low holds the last product.
module pipe_mult #(
  parameter int A_W = 10,
  parameter int B_W = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [A_W-1:0]     i_a,
  input  logic [B_W-1:0]     i_b,
  output logic [A_W+B_W-1:0] o_p
);

  logic [A_W+B_W-1:0] w_a_ext;
  logic [A_W+B_W-1:0] w_b_ext;
  logic [A_W+B_W-1:0] r_p;

  // Zero-extend both operands so the product keeps every bit.
  assign w_a_ext = {{B_W{1'b0}}, i_a};
  assign w_b_ext = {{A_W{1'b0}}, i_b};

  // Product register; holds when not enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p <= '0;
    end else if (i_en) begin
      r_p <= w_a_ext * w_b_ext;
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/neuron_feeder.sv
// Accepts packed x/w/bias frames and streams the four x[k]*w[k] products as a contiguous 4-beat ready frame.
// Latency: beat 0 appears one cycle after the transfer edge; beats 1..3 follow on consecutive cycles.
// Backpressure: in_ready is low only while the one-deep pending slot is full; no downstream backpressure.
module neuron_feeder
  import neuron_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BEATS*X_W-1:0] x,
  input  logic [BEATS*W_W-1:0] w,
  input  logic [BIAS_W-1:0]    bias,
  input  logic                 flush,
  output logic [P_W-1:0]       operand,
  output logic                 ready,
  output logic [BIAS_W-1:0]    B,
  output logic                 frame_done
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [BEAT_W-1:0] r_beat;
  logic [BEAT_W-1:0] w_beat_nxt;
  frame_t            r_act;
  frame_t            r_pend;
  logic              r_pend_full;
  logic              w_pend_full_nxt;
  frame_t            w_in_frame;
  logic              w_xfer;
  logic              w_issue;
  logic              w_load_act_in;
  logic              w_load_act_pend;
  logic              w_load_pend;
  logic [X_W-1:0]    w_x_k;
  logic [W_W-1:0]    w_w_k;
  logic [P_W-1:0]    w_prod;
  logic              r_ready;
  logic              r_done;
  logic [BIAS_W-1:0] r_b;

  // The pending slot is the only place a frame can wait, so acceptance depends on it alone.
  assign in_ready   = ~r_pend_full;
  assign w_xfer     = in_valid & ~r_pend_full;
  assign w_in_frame = {x, w, bias};

  // A beat is issued into the multiplier on every STREAM edge unless this edge aborts.
  assign w_issue = (r_state == STREAM) & ~flush;

  // Next state, beat counter and which register set loads on this edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_pend_full_nxt = r_pend_full;
    w_load_act_in   = 1'b0;
    w_load_act_pend = 1'b0;
    w_load_pend     = 1'b0;
    if (flush) begin
      // Abort wins over everything, including a transfer on the same edge.
      w_state_nxt     = IDLE;
      w_beat_nxt      = FIRST_BEAT;
      w_pend_full_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            w_load_act_in = 1'b1;
            w_state_nxt   = STREAM;
            w_beat_nxt    = FIRST_BEAT;
          end
        end
        STREAM: begin
          if (r_beat == LAST_BEAT) begin
            w_beat_nxt = FIRST_BEAT;
            if (r_pend_full) begin
              // Promote the waiting frame so the next beat 0 follows without a gap.
              w_load_act_pend = 1'b1;
              w_pend_full_nxt = 1'b0;
            end else if (w_xfer) begin
              // Incoming frame bypasses the pending slot on the wrap edge.
              w_load_act_in = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_beat_nxt = r_beat + 1'b1;
            if (w_xfer) begin
              w_load_pend     = 1'b1;
              w_pend_full_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_beat_nxt  = FIRST_BEAT;
        end
      endcase
    end
  end

  // FSM state, beat counter and pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_beat      <= FIRST_BEAT;
      r_pend_full <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_pend_full <= w_pend_full_nxt;
    end
  end

  // Active and pending operand sets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act  <= '0;
      r_pend <= '0;
    end else begin
      if (w_load_act_in) begin
        r_act <= w_in_frame;
      end else if (w_load_act_pend) begin
        r_act <= r_pend;
      end
      if (w_load_pend) begin
        r_pend <= w_in_frame;
      end
    end
  end

  // Element select for the beat being issued this cycle.
  assign w_x_k = elem_x(r_act.x, r_beat);
  assign w_w_k = elem_w(r_act.w, r_beat);

  pipe_mult #(
    .A_W (X_W),
    .B_W (W_W)
  ) u_mult (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (w_issue),
    .i_a     (w_x_k),
    .i_b     (w_w_k),
    .o_p     (w_prod)
  );

  // Beat qualifiers and bias registered alongside the product so they line up with operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_b     <= '0;
    end else begin
      r_ready <= w_issue;
      r_done  <= w_issue & (r_beat == LAST_BEAT);
      if (w_issue && (r_beat == FIRST_BEAT)) begin
        r_b <= r_act.bias;
      end
    end
  end

  assign operand    = w_prod;
  assign ready      = r_ready;
  assign frame_done = r_done;
  assign B          = r_b;

endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder: queue-based reference model compared every cycle,
// directed frames with literal expectations, then randomized traffic with flushes and async resets.
module tb_neuron_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [39:0] in_x = '0;
  logic [39:0] in_w = '0;
  logic [7:0]  in_bias = '0;
  logic        flush = 1'b0;
  logic [19:0] operand;
  logic        ready;
  logic [7:0]  b_out;
  logic        frame_done;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  neuron_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (in_x),
    .w          (in_w),
    .bias       (in_bias),
    .flush      (flush),
    .operand    (operand),
    .ready      (ready),
    .B          (b_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endfunction

  function automatic logic [39:0] pack4(int a, int b, int c, int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  // ---------------- reference model ----------------
  // Accepted frames wait in a queue; the head frame is emitted one beat per
  // edge. At most one frame can wait behind the one in flight.
  typedef struct packed {
    logic [39:0] x;
    logic [39:0] w;
    logic [7:0]  b;
  } mf_t;

  mf_t q[$];
  int  pos = 0;
  longint m_operand = 0;
  int  m_ready = 0, m_b = 0, m_done = 0, m_in_ready = 1;
  bit  m_xfer;

  function automatic longint prod(mf_t f, int k);
    longint xv, wv;
    xv = longint'((f.x >> (k * 10)) & 40'd1023);
    wv = longint'((f.w >> (k * 10)) & 40'd1023);
    return xv * wv;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      pos = 0; m_operand = 0; m_ready = 0; m_b = 0; m_done = 0;
    end else begin
      m_xfer = in_valid && (q.size() < 2);
      if (flush) begin
        q.delete();
        pos = 0; m_ready = 0; m_done = 0;
      end else begin
        if (q.size() > 0) begin
          m_operand = prod(q[0], pos);
          m_ready = 1;
          m_done = (pos == 3) ? 1 : 0;
          if (pos == 0) m_b = int'(q[0].b);
          pos++;
          if (pos == 4) begin
            void'(q.pop_front());
            pos = 0;
          end
        end else begin
          m_ready = 0;
          m_done = 0;
        end
        if (m_xfer) q.push_back({in_x, in_w, in_bias});
      end
    end
    m_in_ready = (q.size() < 2) ? 1 : 0;
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("operand", longint'(operand), m_operand);
      chk("ready", longint'(ready), longint'(m_ready));
      chk("B", longint'(b_out), longint'(m_b));
      chk("frame_done", longint'(frame_done), longint'(m_done));
      chk("in_ready", longint'(in_ready), longint'(m_in_ready));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [39:0] xv, input logic [39:0] wv, input logic [7:0] bv);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_wait_in_ready", longint'(in_ready), 1);
    in_valid = 1'b1; in_x = xv; in_w = wv; in_bias = bv;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic async_reset_check(string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_operand"}, longint'(operand), 0);
    chk({tag, "_rst_ready"}, longint'(ready), 0);
    chk({tag, "_rst_B"}, longint'(b_out), 0);
    chk({tag, "_rst_done"}, longint'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [39:0] xa, wa;
  int exp_a[4];

  initial begin
    xa = pack4(1, 2, 3, 4);
    wa = pack4(10, 20, 30, 40);
    exp_a = '{10, 40, 90, 160};

    // Reset state.
    @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_operand", longint'(operand), 0);
    chk("reset_ready", longint'(ready), 0);
    chk("reset_B", longint'(b_out), 0);
    chk("reset_done", longint'(frame_done), 0);
    chk("reset_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame with hand-computed products.
    send(xa, wa, 8'd5);
    chk("single_idle_before_beat0", longint'(ready), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("single_operand", longint'(operand), longint'(exp_a[k]));
      chk("single_ready", longint'(ready), 1);
      chk("single_B", longint'(b_out), 5);
      chk("single_done", longint'(frame_done), (k == 3) ? 1 : 0);
    end
    @(negedge clk);
    chk("single_ready_after", longint'(ready), 0);
    settle();

    // Maximum operands: no truncation.
    send({4{10'd1023}}, {4{10'd1023}}, 8'd255);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("max_operand", longint'(operand), 1046529);
    end
    settle();

    // Back-to-back: second frame offered while frame 1 beat 0 is on the output.
    send(xa, wa, 8'd5);
    begin
      int cnt, run, best, b_sw;
      @(negedge clk);
      cnt = ready ? 1 : 0; run = cnt; best = run; b_sw = -1;
      in_valid = 1'b1; in_x = pack4(2, 2, 2, 2); in_w = pack4(3, 3, 3, 3); in_bias = 8'd9;
      for (int i = 1; i < 12; i++) begin
        @(negedge clk);
        in_valid = 1'b0;
        if (i == 1) chk("b2b_in_ready_low", longint'(in_ready), 0);
        if (ready) begin cnt++; run++; end else run = 0;
        if (run > best) best = run;
        if (b_sw < 0 && b_out == 8'd9) b_sw = i;
      end
      chk("b2b_ready_cycles", cnt, 8);
      chk("b2b_ready_run", best, 8);
      chk("b2b_B_switch_beat", b_sw, 4);
    end
    settle();

    // Transfer on the beat-3 edge with pending empty: no gap.
    send(xa, wa, 8'd5);
    repeat (3) @(negedge clk);
    in_valid = 1'b1; in_x = pack4(2, 2, 2, 2); in_w = pack4(3, 3, 3, 3); in_bias = 8'd9;
    @(negedge clk);
    in_valid = 1'b0;
    chk("wrap_last_operand", longint'(operand), 160);
    chk("wrap_last_done", longint'(frame_done), 1);
    @(negedge clk);
    chk("wrap_next_ready", longint'(ready), 1);
    chk("wrap_next_operand", longint'(operand), 6);
    chk("wrap_next_B", longint'(b_out), 9);
    settle();

    // Flush at beat 2 with pending full.
    send(xa, wa, 8'd7);
    in_valid = 1'b1; in_x = pack4(5, 5, 5, 5); in_w = pack4(5, 5, 5, 5); in_bias = 8'd1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", longint'(ready), 0);
    chk("flush_in_ready", longint'(in_ready), 1);
    chk("flush_B_hold", longint'(b_out), 7);
    chk("flush_operand_hold", longint'(operand), 40);
    @(negedge clk);
    chk("flush_pending_dropped", longint'(ready), 0);
    send(pack4(4, 3, 2, 1), pack4(1, 1, 1, 1), 8'd3);
    @(negedge clk);
    chk("post_flush_operand", longint'(operand), 4);
    chk("post_flush_B", longint'(b_out), 3);
    settle();

    // Async reset mid-frame, then a clean frame.
    send(xa, wa, 8'd5);
    @(negedge clk);
    @(negedge clk);
    async_reset_check("mid");
    send(xa, wa, 8'd5);
    @(negedge clk);
    chk("after_rst_operand", longint'(operand), 10);
    chk("after_rst_B", longint'(b_out), 5);
    settle();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) != 0);
      in_x = ($urandom_range(0, 7) == 0) ? {4{10'd1023}} : 40'({$urandom(), $urandom()});
      in_w = ($urandom_range(0, 7) == 0) ? {4{10'd1023}} : 40'({$urandom(), $urandom()});
      in_bias = 8'($urandom());
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 299) == 0) begin
        in_valid = 1'b0;
        flush = 1'b0;
        async_reset_check("rand");
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    settle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/neuron_feeder.md
# neuron_feeder

Upstream operand sequencer for the neuron accumulator. It accepts one packed set of four inputs, four weights and a bias. It multiplies each input/weight pair through a registered multiplier and streams the four 20-bit products as a contiguous 4-beat `ready` frame, so the accumulator's 4-state cycle stays frame-aligned. A one-deep pending buffer allows back-to-back frames with no gap in `ready`.

## Interface
Parameters:
- `X_W`, 10: input element width (unsigned)
- `W_W`, 10: weight element width (unsigned)
- `P_W`, 20: product width, X_W+W_W
- `BIAS_W`, 8: bias width
- `BEATS`, 4: products per frame; fixed to match the accumulator cycle

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  new frame request
- `in_ready`  out  1  frame can be accepted this cycle
- `x`  in  4*X_W  inputs; element k is bits [k*X_W +: X_W], k=0 streamed first
- `w`  in  4*W_W  weights, same packing as `x`
- `bias`  in  BIAS_W  bias for this frame
- `flush`  in  1  synchronous abort of the current and pending frames
- `operand`  out  P_W  product beat to the accumulator
- `ready`  out  1  high while `operand` carries a valid beat
- `B`  out  BIAS_W  bias of the frame in flight
- `frame_done`  out  1  one-cycle pulse on the last beat of a frame

## Operation
- Transfer: `in_valid & in_ready` at a rising edge captures `x`, `w`, `bias`.
- Storage: one active register set plus one pending register set.
- `in_ready` = pending slot empty. It depends only on registered state, never on `in_valid`.
- FSM states:
  - IDLE: no frame in flight. A transfer loads the active set and goes to STREAM at beat 0.
  - STREAM: beat counter 0..3.
    - At beat 3, if pending is full (or a transfer occurs in the same cycle), the pending/incoming set becomes active and the FSM stays in STREAM with beat 0.
    - Otherwise the FSM returns to IDLE.
- Multiplier: one registered stage. `operand` = x[k]*w[k] of the active set, full P_W width, unsigned, no truncation.
- `B`: loaded from the frame's bias when that frame's beat 0 appears on `operand`. Held stable through all 4 beats and afterwards until the next frame's beat 0.
- `frame_done`: high on the cycle `operand` carries beat 3.
- `flush` (sampled at an edge):
  - clears the FSM to IDLE and empties pending; `ready` goes low at that edge
  - `operand` and `B` keep their last values
  - a transfer in the same cycle is discarded; `flush` has priority
- Simultaneous events:
  - A transfer during beat 3 with pending empty goes straight to active, with no gap.
  - A transfer while pending is full cannot occur (`in_ready` is low).

## Timing
- Reset values: `operand`=0, `ready`=0, `B`=0, `frame_done`=0, `in_ready`=1, FSM=IDLE, pending empty.
- Latency: a transfer at edge E0 puts beat 0 on `operand` with `ready`=1 after E1. Beats 1..3 follow after E2..E4.
- A frame is always exactly 4 consecutive `ready` cycles. `ready` never drops mid-frame except on `flush` or reset.
- Back-to-back: with pending full at beat 3, beat 0 of the next frame appears on the next cycle with `ready` continuously high. The frame boundary then coincides with the accumulator's wrap.
- `in_ready` deasserts the cycle after the pending slot fills. It reasserts the cycle after the pending set is promoted to active.
- Asynchronous reset mid-frame: all outputs take their reset values immediately and the partial frame is lost. The first frame after deassertion starts cleanly at beat 0.

## Structure
- Shared package `neuron_pkg`: X_W, W_W, P_W, BIAS_W, BEATS constants, and the FSM state encoding (IDLE, STREAM). The accumulator uses the same P_W/BIAS_W.
- One sub-module, `pipe_mult`: X_W×W_W unsigned multiplier with an output register, with async active-low reset and an enable.
- Top level: FSM, beat counter, active/pending register sets, element select mux.

## Test plan
- Single frame: x={1,2,3,4}, w={10,20,30,40}, bias=5 → `operand` 10,40,90,160 on cycles E1..E4, `ready`=1 for exactly those 4 cycles, `B`=5 from E1, `frame_done` at E4.
- Max values: all x=1023, all w=1023 → every beat = 1046529, no truncation. Downstream sum = 4186116+bias.
- Back-to-back: second transfer during frame 1 beat 1 → `in_ready` low from the next cycle, frame 2 beat 0 immediately after frame 1 beat 3, `ready` high for 8 straight cycles, `B` switches exactly at frame 2 beat 0.
- Transfer on beat 3 with pending empty → no gap in `ready`. `in_valid` held while pending is full → no capture until `in_ready` returns.
- `flush` at beat 2 with pending full → `ready`=0 next cycle, pending discarded, `in_ready`=1, and the next frame streams normally.
- `rst_n` low asynchronously mid-frame → `ready`, `operand`, `B`, `frame_done` zero without a clock edge. After release, a new frame yields correct products from beat 0.
